div_unit: RTL and testbench

Multi-cycle RV32M divide/remainder unit for DIV, DIVU, REM and REMU. It sits beside the `alu` in the execute stage. The ALU handles single-cycle add, subtract, logic and set-less-than; this block handles the inverse of multiplication and takes many cycles to do it. It uses a start/busy/done handshake so the control unit can stall the core while it runs. Internally it is a radix-2 restoring divider, one quotient bit per clock, with sign fix-up and RISC-V special-case handling.

---
 rtl/div_if.sv | 21 ++
 rtl/div_unit.sv | 101 ++++++++++
 tb/tb_div_unit.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/div_if.sv
// Start/busy/done handshake between the execute-stage control unit and the divider.
interface div_if;
  logic        Start;
  logic [1:0]  DivOp;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] Result;
  logic        Busy;
  logic        Done;
  logic        DivByZero;

  modport master (
    output Start, DivOp, A, B,
    input  Result, Busy, Done, DivByZero
  );

  modport slave (
    input  Start, DivOp, A, B,
    output Result, Busy, Done, DivByZero
  );
endinterface

// File: rtl/div_unit.sv
// RV32M DIV/DIVU/REM/REMU: radix-2 restoring divider, one quotient bit per clock,
// with sign fix-up and RISC-V divide-by-zero / signed-overflow handling.
module div_unit (
  input logic  clk,
  input logic  rst,
  div_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [31:0] rem_q, quo_q, dsr_q;
  logic        op_rem, neg_q, neg_r, dbz;

  logic        accept, sgn_op, b_zero, ovf, special;
  logic [31:0] special_res;
  logic [32:0] rem_sh, trial;
  logic [31:0] rem_nxt, quo_nxt, final_res;

  function automatic logic [31:0] magnitude(input logic signed [31:0] v, input logic sgn);
    return (sgn && (v < 0)) ? 32'(-v) : 32'(v);
  endfunction

  function automatic logic [31:0] apply_sign(input logic [31:0] mag, input logic neg);
    logic signed [31:0] s;
    s = mag;
    return neg ? 32'(-s) : mag;
  endfunction

  assign accept  = bus.Start && (state != CALC);
  assign sgn_op  = ~bus.DivOp[0];
  assign b_zero  = (bus.B == 32'd0);
  assign ovf     = sgn_op && (bus.A == 32'h8000_0000) && (bus.B == 32'hFFFF_FFFF);
  assign special = b_zero || ovf;

  always_comb begin
    special_res = 32'd0;
    if (b_zero)
      special_res = bus.DivOp[1] ? bus.A : 32'hFFFF_FFFF;
    else if (ovf)
      special_res = bus.DivOp[1] ? 32'd0 : 32'h8000_0000;
  end

  // Iteration: shift the next dividend bit into the remainder, trial-subtract, restore on borrow.
  assign rem_sh    = {rem_q, quo_q[31]};
  assign trial     = rem_sh - {1'b0, dsr_q};
  assign rem_nxt   = trial[32] ? rem_sh[31:0] : trial[31:0];
  assign quo_nxt   = {quo_q[30:0], ~trial[32]};
  assign final_res = op_rem ? apply_sign(rem_nxt, neg_r) : apply_sign(quo_nxt, neg_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (accept) begin
      state_nxt = special ? DONE : CALC;
    end else begin
      case (state)
        CALC:    if (cnt == 5'd0) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= 5'd0;
      rem_q      <= 32'd0;
      quo_q      <= 32'd0;
      dsr_q      <= 32'd0;
      op_rem     <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      dbz        <= 1'b0;
      bus.Result <= 32'd0;
    end else if (accept) begin
      cnt    <= 5'd31;
      rem_q  <= 32'd0;
      quo_q  <= magnitude(bus.A, sgn_op);
      dsr_q  <= magnitude(bus.B, sgn_op);
      op_rem <= bus.DivOp[1];
      neg_q  <= sgn_op && (bus.A[31] ^ bus.B[31]);
      neg_r  <= sgn_op && bus.A[31];
      dbz    <= b_zero;
      if (special) bus.Result <= special_res;
    end else if (state == CALC) begin
      cnt   <= cnt - 5'd1;
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
      if (cnt == 5'd0) bus.Result <= final_res;
    end
  end

  assign bus.Busy      = (state == CALC);
  assign bus.Done      = (state == DONE);
  assign bus.DivByZero = (state == DONE) && dbz;
endmodule

// File: tb/tb_div_unit.sv
// Directed plus randomised bench for div_unit with an expected-result scoreboard.
module tb_div_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  div_if bus ();
  div_unit dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] res;
    logic        dbz;
    int          lat;
    int          busy;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;
  int   lat;
  int   busy_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sd;
    logic [31:0] q, r;
    sa = a;
    sd = b;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0;
    end else if (!op[0]) begin
      q = sa / sd; r = sa % sd;
    end else begin
      q = a / b; r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  // Caller must be at a negedge; returns at the negedge after the accepting edge.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res);
    exp_t e;
    logic sp;
    sp     = (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    e.res  = exp_res;
    e.dbz  = (b == 32'd0);
    e.lat  = sp ? 1 : 33;
    e.busy = sp ? 0 : 32;
    sbq.push_back(e);
    bus.Start = 1'b1;
    bus.DivOp = op;
    bus.A     = a;
    bus.B     = b;
    @(negedge clk);
    bus.Start = 1'b0;
    lat       = 1;
    busy_cnt  = 0;
  endtask

  task automatic wait_done(input string tag, input int inject_at);
    exp_t e;
    while (!bus.Done && lat < 40) begin
      if (bus.Busy) busy_cnt++;
      if (lat == inject_at) begin
        bus.Start = 1'b1; bus.DivOp = 2'b01; bus.A = 32'd50; bus.B = 32'd5;
      end else begin
        bus.Start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.Start = 1'b0;
    check({tag, "_done"}, 32'(bus.Done), 32'd1);
    if (sbq.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(sbq.size()), 32'd1);
    end else begin
      e = sbq.pop_front();
      check({tag, "_res"}, bus.Result, e.res);
      check({tag, "_dbz"}, 32'(bus.DivByZero), 32'(e.dbz));
      check({tag, "_lat"}, 32'(lat), 32'(e.lat));
      check({tag, "_busy"}, 32'(busy_cnt), 32'(e.busy));
      check({tag, "_excl"}, 32'(bus.Busy), 32'd0);
    end
  endtask

  task automatic count_dones(input string tag, input int cycles);
    int n;
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.Done) n++;
    end
    check(tag, 32'(n), 32'd0);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    logic [31:0] held;
    bus.Start = 1'b0; bus.DivOp = 2'b00; bus.A = 32'd0; bus.B = 32'd0;

    @(negedge clk);
    check("rst_busy", 32'(bus.Busy), 32'd0);
    check("rst_done", 32'(bus.Done), 32'd0);
    check("rst_dbz", 32'(bus.DivByZero), 32'd0);
    check("rst_result", bus.Result, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    start_op(2'b01, 32'd100, 32'd7, 32'd14);                   wait_done("divu", 0); @(negedge clk);
    start_op(2'b11, 32'd100, 32'd7, 32'd2);                    wait_done("remu", 0); @(negedge clk);
    start_op(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);      wait_done("div_neg", 0); @(negedge clk);
    start_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);      wait_done("rem_neg", 0); @(negedge clk);
    start_op(2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);      wait_done("div_negb", 0); @(negedge clk);
    start_op(2'b01, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF);      wait_done("divu_z", 0); @(negedge clk);
    start_op(2'b11, 32'h1234_5678, 32'd0, 32'h1234_5678);      wait_done("remu_z", 0);

    held = bus.Result;
    repeat (3) @(negedge clk);
    check("idle_hold", bus.Result, held);
    check("idle_dbz", 32'(bus.DivByZero), 32'd0);

    start_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000); wait_done("div_ovf", 0); @(negedge clk);
    start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);         wait_done("rem_ovf", 0); @(negedge clk);
    start_op(2'b00, 32'd12, 32'd0, 32'hFFFF_FFFF);                wait_done("div_z", 0); @(negedge clk);

    start_op(2'b01, 32'd100, 32'd7, 32'd14);
    wait_done("ignore", 5);
    count_dones("ignore_noqueue", 40);
    check("ignore_hold", bus.Result, 32'd14);

    for (int i = 0; i < 6; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (i % 3 == 2) ra = -ra;
      start_op(rop, ra, rb, model(rop, ra, rb));
      wait_done("rand", 0);
      if (i % 2 == 1) @(negedge clk);
    end

    start_op(2'b01, 32'd1000, 32'd10, 32'd100);
    wait_done("b2b_first", 0);
    start_op(2'b00, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2);
    wait_done("b2b_second", 0);
    start_op(2'b11, 32'd77, 32'd0, 32'd77);
    wait_done("b2b_special", 0);
    @(negedge clk);

    start_op(2'b01, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555);
    repeat (9) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_busy", 32'(bus.Busy), 32'd0);
    check("abort_done", 32'(bus.Done), 32'd0);
    check("abort_result", bus.Result, 32'd0);
    sbq.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    count_dones("abort_nodone", 40);

    start_op(2'b01, 32'd9, 32'd3, 32'd3);
    wait_done("post_rst", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
